// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared constants and FSM encoding for the ring-oscillator
// gated measurement stage.
package ro_meas_pkg;

  // Default and largest supported counter/result width.
  localparam int CNT_W_DEF = 24;
  localparam int MAX_CNT_W = 24;

  // byte_sel value that routes the status byte to dout.
  localparam logic [1:0] STATUS_SEL = 2'd3;

  // Measurement FSM states; the encoding is visible in the status byte.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_COUNT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACKW  = 3'd4
  } meas_state_t;

endpackage

// File: rtl/ro_sync.sv
// ro_sync: SYNC_STAGES-deep flop chain that brings an asynchronous pin
// level into the divider-tap clock domain. Resets to 0.
module ro_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic dff_q_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  // Shift the pin level through the chain; the last flop is the synchronized value
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/ro_gated_counter.sv
// ro_gated_counter: counts divider-tap cycles while a synchronized gate is
// high, latches the count, and presents it byte-wise under a four-phase
// level acknowledge.
// Optional feature: define RO_CNT_SATURATE_EN to saturate the counter and
// report overflow; otherwise the counter wraps and ovf is constant 0.
module ro_gated_counter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       dff_q_clk,
  input  logic       rst_n,
  input  logic       gate_async,
  input  logic       ack_async,
  input  logic [1:0] byte_sel,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy,
  output logic       ovf
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  logic                 g_s;
  logic                 a_s;
  logic                 g_d;
  logic                 rise;
  logic [WARM_W-1:0]    warm;
  logic                 sync_ready;
  meas_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic [CNT_W-1:0]     result;
  logic [MAX_CNT_W-1:0] result_ext;
  logic [7:0]           status;

  ro_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gate_sync (
    .dff_q_clk (dff_q_clk),
    .rst_n     (rst_n),
    .d         (gate_async),
    .q         (g_s)
  );

  ro_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .dff_q_clk (dff_q_clk),
    .rst_n     (rst_n),
    .d         (ack_async),
    .q         (a_s)
  );

  // Previous synchronized gate level, for rising-edge detection
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      g_d <= 1'b0;
    end else begin
      g_d <= g_s;
    end
  end

  assign rise = g_s & ~g_d;

  // The synchronizer comes out of reset holding zeros, which would look like
  // a low gate. IDLE waits until the chain carries real post-reset samples so
  // a gate already high at reset release cannot open a truncated window.
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= '0;
    end else if (!sync_ready) begin
      warm <= warm + WARM_W'(1);
    end
  end

  assign sync_ready = (warm == WARM_W'(SYNC_STAGES));

`ifdef RO_CNT_SATURATE_EN
  logic cnt_full;
  logic ovf_int;

  assign cnt_full = &cnt;
  assign cnt_next = cnt_full ? cnt : cnt + CNT_W'(1);

  // Sticky overflow for the window in progress
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_int <= 1'b0;
    end else if (state == ST_ARMED && rise) begin
      ovf_int <= 1'b0;
    end else if (state == ST_COUNT && g_s && cnt_full) begin
      ovf_int <= 1'b1;
    end
  end

  // Overflow flag latched alongside the result at window close
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == ST_COUNT && !g_s) begin
      ovf <= ovf_int;
    end
  end
`else
  assign cnt_next = cnt + CNT_W'(1);
  assign ovf      = 1'b0;
`endif

  // Measurement sequencing: arm, count the window, hold the result, handshake
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_ready && !g_s) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (rise) begin
            // The rising cycle itself is the first counted cycle
            cnt   <= CNT_W'(1);
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (g_s) begin
            cnt <= cnt_next;
          end else begin
            result <= cnt;
            valid  <= 1'b1;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (a_s) begin
            valid <= 1'b0;
            state <= ST_ACKW;
          end
        end
        ST_ACKW: begin
          if (!a_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state == ST_COUNT);
  assign status = {valid, ovf, busy, 2'b00, state};

  // Byte mux; bytes above the result width read as zero via zero extension
  always_comb begin
    result_ext              = '0;
    result_ext[CNT_W-1:0]   = result;
    dout                    = 8'h00;
    if (byte_sel == STATUS_SEL) begin
      dout = status;
    end else begin
      case (byte_sel)
        2'd0:    dout = result_ext[7:0];
        2'd1:    dout = result_ext[15:8];
        2'd2:    dout = result_ext[23:16];
        default: dout = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_gated_counter.sv
// tb_ro_gated_counter: drives a 24-bit and an 8-bit instance from the same
// pins and checks both against a window-level reference model every cycle,
// plus literal expectations for the documented scenarios.
module tb_ro_gated_counter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] byte_sel = 2'd0;
  logic [7:0] dout24, dout8;
  logic       valid24, busy24, ovf24;
  logic       valid8, busy8, ovf8;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b1;

  ro_gated_counter #(.CNT_W(24), .SYNC_STAGES(S)) u_dut24 (
    .dff_q_clk (clk),
    .rst_n     (rst_n),
    .gate_async(gate),
    .ack_async (ack),
    .byte_sel  (byte_sel),
    .dout      (dout24),
    .valid     (valid24),
    .busy      (busy24),
    .ovf       (ovf24)
  );

  ro_gated_counter #(.CNT_W(8), .SYNC_STAGES(S)) u_dut8 (
    .dff_q_clk (clk),
    .rst_n     (rst_n),
    .gate_async(gate),
    .ack_async (ack),
    .byte_sel  (byte_sel),
    .dout      (dout8),
    .valid     (valid8),
    .busy      (busy8),
    .ovf       (ovf8)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase numbers follow the documented state encoding (0 idle .. 4 ack wait).
  bit          gq[S];
  bit          aq[S];
  int          m_phase;
  longint      m_cnt;
  int          m_age;
  bit          m_gd, m_valid, m_ovf24, m_ovf8;
  logic [23:0] m_res24;
  logic [7:0]  m_res8;

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      gq[i] = 1'b0;
      aq[i] = 1'b0;
    end
    m_phase = 0; m_cnt = 0; m_age = 0; m_gd = 1'b0; m_valid = 1'b0;
    m_ovf24 = 1'b0; m_ovf8 = 1'b0; m_res24 = '0; m_res8 = '0;
  endtask

  task automatic capture();
`ifdef RO_CNT_SATURATE_EN
    m_ovf24 = (m_cnt > 64'd16777215);
    m_res24 = m_ovf24 ? 24'hFFFFFF : 24'(m_cnt);
    m_ovf8  = (m_cnt > 64'd255);
    m_res8  = m_ovf8 ? 8'hFF : 8'(m_cnt);
`else
    m_ovf24 = 1'b0;
    m_res24 = 24'(m_cnt % 64'd16777216);
    m_ovf8  = 1'b0;
    m_res8  = 8'(m_cnt % 64'd256);
`endif
  endtask

  task automatic model_step();
    bit gs, as_, rise, ready;
    if (!rst_n) begin
      model_reset();
      return;
    end
    gs    = gq[S-1];
    as_   = aq[S-1];
    rise  = gs && !m_gd;
    ready = (m_age >= S);
    if (m_age < S) m_age++;
    case (m_phase)
      0: if (ready && !gs) m_phase = 1;
      1: if (rise) begin m_cnt = 1; m_phase = 2; end
      2: if (gs) m_cnt++;
         else begin capture(); m_valid = 1'b1; m_phase = 3; end
      3: if (as_) begin m_valid = 1'b0; m_phase = 4; end
      4: if (!as_) m_phase = 0;
      default: m_phase = 0;
    endcase
    m_gd = gs;
    for (int i = S-1; i > 0; i--) begin
      gq[i] = gq[i-1];
      aq[i] = aq[i-1];
    end
    gq[0] = gate;
    aq[0] = ack;
  endtask

  function automatic logic [7:0] exp_dout(bit wide);
    logic [23:0] r;
    bit          ov;
    r  = wide ? m_res24 : {16'h0000, m_res8};
    ov = wide ? m_ovf24 : m_ovf8;
    case (byte_sel)
      2'd0:    return r[7:0];
      2'd1:    return r[15:8];
      2'd2:    return r[23:16];
      default: return {m_valid, ov, (m_phase == 2), 2'b00, 3'(m_phase)};
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid24", 32'(valid24), 32'(m_valid));
      check("busy24",  32'(busy24),  32'(m_phase == 2));
      check("ovf24",   32'(ovf24),   32'(m_ovf24));
      check("dout24",  32'(dout24),  32'(exp_dout(1'b1)));
      check("valid8",  32'(valid8),  32'(m_valid));
      check("busy8",   32'(busy8),   32'(m_phase == 2));
      check("ovf8",    32'(ovf8),    32'(m_ovf8));
      check("dout8",   32'(dout8),   32'(exp_dout(1'b0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic window(input int n);
    gate = 1'b1;
    tick(n);
    gate = 1'b0;
  endtask

  task automatic settle();
    tick(S + 3);
  endtask

  task automatic sel_read(input logic [1:0] s, output logic [7:0] d24, output logic [7:0] d8);
    @(negedge clk);
    #2 byte_sel = s;
    #1;
    d24 = dout24;
    d8  = dout8;
  endtask

  task automatic check_bytes(input string tag, input logic [23:0] e24, input logic [7:0] e8);
    logic [7:0] d24, d8;
    sel_read(2'd0, d24, d8);
    check({tag, "_b0_24"}, 32'(d24), 32'(e24[7:0]));
    check({tag, "_b0_8"},  32'(d8),  32'(e8));
    sel_read(2'd1, d24, d8);
    check({tag, "_b1_24"}, 32'(d24), 32'(e24[15:8]));
    check({tag, "_b1_8"},  32'(d8),  32'h00);
    sel_read(2'd2, d24, d8);
    check({tag, "_b2_24"}, 32'(d24), 32'(e24[23:16]));
    check({tag, "_b2_8"},  32'(d8),  32'h00);
  endtask

  task automatic check_status(input string tag, input logic [7:0] e24, input logic [7:0] e8);
    logic [7:0] d24, d8;
    sel_read(2'd3, d24, d8);
    check({tag, "_st24"}, 32'(d24), 32'(e24));
    check({tag, "_st8"},  32'(d8),  32'(e8));
  endtask

  task automatic do_ack(input bit check_lat);
    int k;
    k = 0;
    ack = 1'b1;
    while (valid24 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (check_lat) check("ack_to_valid_low", 32'(k), 32'(S + 1));
    ack = 1'b0;
    tick(S + 4);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] st8_sat;
    logic [7:0] b0_8_300;

    gate = 1'b1;
    tick(3);
    #1;
    check("rst_valid", 32'(valid24), 32'h0);
    check("rst_dout0", 32'(dout24), 32'h00);

    // Reset release with gate already high: stays idle
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    check_status("gate_high_at_release", 8'h00, 8'h00);
    check("no_valid_after_high_release", 32'(valid24), 32'h0);

    // Clean 100-cycle window
    gate = 1'b0;
    tick(5);
    window(100);
    settle();
    check_bytes("w100", 24'h000064, 8'h64);
    check_status("w100", 8'h83, 8'h83);

    // Acknowledge handshake and return to armed
    do_ack(1'b1);
    check_status("after_ack", 8'h01, 8'h01);

    // 5-cycle window, ack, then 7-cycle window
    window(5);
    settle();
    check_bytes("w5", 24'h000005, 8'h05);
    do_ack(1'b1);
    window(7);
    settle();
    check_bytes("w7", 24'h000007, 8'h07);

    // 300-cycle window: 8-bit instance overflows
    do_ack(1'b1);
    window(300);
    settle();
`ifdef RO_CNT_SATURATE_EN
    b0_8_300 = 8'hFF;
    st8_sat  = 8'hC3;
    check("ovf8_300", 32'(ovf8), 32'h1);
`else
    b0_8_300 = 8'h2C;
    st8_sat  = 8'h83;
    check("ovf8_300", 32'(ovf8), 32'h0);
`endif
    check("ovf24_300", 32'(ovf24), 32'h0);
    check_bytes("w300", 24'h00012C, b0_8_300);
    check_status("w300", 8'h83, st8_sat);

    // Gate pulse while holding a result is ignored
    do_ack(1'b1);
    window(10);
    settle();
    window(4);
    settle();
    check("hold_valid", 32'(valid24), 32'h1);
    check("hold_busy", 32'(busy24), 32'h0);
    check_bytes("hold_w10", 24'h00000A, 8'h0A);
    check_status("hold_w10", 8'h83, 8'h83);

    // Reset in the middle of a window discards it
    do_ack(1'b1);
    gate = 1'b1;
    tick(50 + S);
    check("mid_count_busy", 32'(busy24), 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_valid", 32'(valid24), 32'h0);
    check("rst_mid_busy", 32'(busy24), 32'h0);
    check("rst_mid_ovf", 32'(ovf24), 32'h0);
    byte_sel = 2'd3;
    #1;
    check("rst_mid_status24", 32'(dout24), 32'h00);
    check("rst_mid_status8", 32'(dout8), 32'h00);
    gate = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    window(30);
    settle();
    check_bytes("w30", 24'h00001E, 8'h1E);

    // Randomized phase against the model
    do_ack(1'b0);
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 9) begin
        window(($urandom_range(0, 7) == 0) ? $urandom_range(250, 320) : $urandom_range(1, 30));
        tick($urandom_range(0, 5));
      end else if (r < 14) begin
        ack = ~ack;
        tick($urandom_range(1, 8));
      end else if (r < 17) begin
        @(negedge clk);
        #2 byte_sel = 2'($urandom_range(0, 3));
      end else if (r < 19) begin
        tick($urandom_range(1, 10));
      end else begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        gate = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    ack = 1'b0;
    gate = 1'b0;
    settle();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
